// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared types and constants for the I/O interrupt controller
package io_ctrl_pkg;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    localparam int         DATA_W_DEF = 8;
    localparam logic       FGO_RST    = 1'b1;
    localparam logic [1:0] IMSK_RST   = 2'b11;

endpackage

// File: rtl/io_flag_ff.sv
// rtl/io_flag_ff.sv - single flag flop with set/clear inputs, clear wins
module io_flag_ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic q
);

    // Clear beats set so simultaneous disable/enable strobes leave the flag low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end
    end

endmodule

// File: rtl/io_interrupt_controller.sv
// rtl/io_interrupt_controller.sv - INPR/OUTR, FGI/FGO/IEN and interrupt request (optional mask: IO_IRQ_MASK_EN)
module io_interrupt_controller
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              inp_rd,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] ac_lo,
    input  logic              ion,
    input  logic              iof,
    input  logic              int_ack,
`ifdef IO_IRQ_MASK_EN
    input  logic              imsk_wr,
    input  logic [1:0]        imsk_data,
`endif
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              int_req,
    output logic              io_err
);

    out_state_t        out_state;
    logic [DATA_W-1:0] outr;
    logic              in_take;
    logic              inp_bad;
    logic              out_bad;

    // A byte is only taken while FGI is low; an INP in the same cycle clears FGI first
    assign in_ready = ~fgi;
    assign in_take  = in_valid & ~fgi;
    assign inp_bad  = inp_rd & ~fgi;
    assign out_bad  = out_wr & (out_state == OUT_SEND);
    assign out_data = outr;

    io_flag_ff #(.RST_VAL(1'b0)) u_fgi (
        .clock (clock),
        .reset (reset),
        .set   (in_take),
        .clr   (inp_rd & fgi),
        .q     (fgi)
    );

    io_flag_ff #(.RST_VAL(FGO_RST)) u_fgo (
        .clock (clock),
        .reset (reset),
        .set   ((out_state == OUT_SEND) & out_ready),
        .clr   ((out_state == OUT_IDLE) & out_wr),
        .q     (fgo)
    );

    io_flag_ff #(.RST_VAL(1'b0)) u_ien (
        .clock (clock),
        .reset (reset),
        .set   (ion),
        .clr   (iof | int_ack),
        .q     (ien)
    );

    // Input register captures the device byte on an accepted transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inpr <= '0;
        end else if (in_take) begin
            inpr <= in_data;
        end
    end

    // Output handshake FSM; OUTR is frozen while a byte is on offer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_state <= OUT_IDLE;
            out_valid <= 1'b0;
            outr      <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (out_wr) begin
                        outr      <= ac_lo;
                        out_state <= OUT_SEND;
                        out_valid <= 1'b1;
                    end
                end
                OUT_SEND: begin
                    if (out_ready) begin
                        out_state <= OUT_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_state <= OUT_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Error pulse one cycle after an INP with no byte or an OUT while busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_err <= 1'b0;
        end else begin
            io_err <= inp_bad | out_bad;
        end
    end

`ifdef IO_IRQ_MASK_EN
    logic [1:0] imsk;

    // Per-flag interrupt mask, both sources enabled out of reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imsk <= IMSK_RST;
        end else if (imsk_wr) begin
            imsk <= imsk_data;
        end
    end

    assign int_req = ien & ((fgi & imsk[0]) | (fgo & imsk[1]));
`else
    assign int_req = ien & (fgi | fgo);
`endif

endmodule

// File: tb/tb_io_interrupt_controller.sv
// tb/tb_io_interrupt_controller.sv - directed self-checking bench for io_interrupt_controller
module tb_io_interrupt_controller;

    localparam int DATA_W = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              inp_rd;
    logic              out_wr;
    logic [DATA_W-1:0] ac_lo;
    logic              ion;
    logic              iof;
    logic              int_ack;
`ifdef IO_IRQ_MASK_EN
    logic              imsk_wr;
    logic [1:0]        imsk_data;
`endif
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              fgo;
    logic              ien;
    logic              int_req;
    logic              io_err;

    int passed = 0;
    int total  = 0;

    logic [DATA_W-1:0] in_q[$];
    logic [DATA_W-1:0] out_q[$];
    logic [DATA_W-1:0] exp_b;

    always #5 clock = ~clock;

    io_interrupt_controller #(.DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .inp_rd    (inp_rd),
        .out_wr    (out_wr),
        .ac_lo     (ac_lo),
        .ion       (ion),
        .iof       (iof),
        .int_ack   (int_ack),
`ifdef IO_IRQ_MASK_EN
        .imsk_wr   (imsk_wr),
        .imsk_data (imsk_data),
`endif
        .inpr      (inpr),
        .fgi       (fgi),
        .fgo       (fgo),
        .ien       (ien),
        .int_req   (int_req),
        .io_err    (io_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; inp_rd = 0;
        out_wr = 0; ac_lo = '0; ion = 0; iof = 0; int_ack = 0;
`ifdef IO_IRQ_MASK_EN
        imsk_wr = 0; imsk_data = 2'b00;
`endif
        step(); step();
        reset = 1'b0;
        step();

        chk("rst_fgi", fgi, 0);
        chk("rst_fgo", fgo, 1);
        chk("rst_ien", ien, 0);
        chk("rst_int_req", int_req, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_io_err", io_err, 0);

        // input transfer
        in_valid = 1; in_data = 8'hA5; in_q.push_back(8'hA5);
        step();
        in_valid = 0;
        exp_b = in_q.pop_front();
        chk("in_inpr", inpr, exp_b);
        chk("in_fgi", fgi, 1);
        chk("in_ready_low", in_ready, 0);
        inp_rd = 1;
        step();
        inp_rd = 0;
        chk("inp_fgi", fgi, 0);
        chk("inp_inpr_held", inpr, 8'hA5);
        chk("inp_no_err", io_err, 0);

        // illegal INP
        inp_rd = 1;
        step();
        inp_rd = 0;
        chk("inp_bad_err", io_err, 1);
        chk("inp_bad_fgi", fgi, 0);
        step();
        chk("inp_bad_err_pulse", io_err, 0);

        // INP and new byte in the same cycle
        in_valid = 1; in_data = 8'hB7; in_q.push_back(8'hB7);
        step();
        exp_b = in_q.pop_front();
        chk("b7_inpr", inpr, exp_b);
        in_data = 8'hC8; inp_rd = 1; in_q.push_back(8'hC8);
        step();
        inp_rd = 0;
        chk("race_fgi", fgi, 0);
        chk("race_inpr_held", inpr, 8'hB7);
        step();
        in_valid = 0;
        exp_b = in_q.pop_front();
        chk("race_inpr_next", inpr, exp_b);
        chk("race_fgi_next", fgi, 1);
        inp_rd = 1;
        step();
        inp_rd = 0;

        // output transfer
        ac_lo = 8'h3C; out_wr = 1; out_q.push_back(8'h3C);
        step();
        out_wr = 0;
        chk("out_fgo", fgo, 0);
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, out_q[0]);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("out_hold_valid", out_valid, 1);
        end
        ac_lo = 8'hFF; out_wr = 1;
        step();
        out_wr = 0;
        chk("out_busy_err", io_err, 1);
        chk("out_busy_data", out_data, out_q[0]);
        out_ready = 1;
        if (out_valid) begin
            exp_b = out_q.pop_front();
            chk("out_xfer_data", out_data, exp_b);
        end
        step();
        out_ready = 0;
        chk("out_done_fgo", fgo, 1);
        chk("out_done_valid", out_valid, 0);
        chk("out_q_empty", out_q.size(), 0);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("idle_ready_valid", out_valid, 0);
        chk("idle_ready_fgo", fgo, 1);

        // interrupt enable
        ion = 1;
        step();
        ion = 0;
        chk("ion_ien", ien, 1);
        chk("ion_int_req", int_req, 1);
        int_ack = 1;
        step();
        int_ack = 0;
        chk("ack_ien", ien, 0);
        chk("ack_int_req", int_req, 0);
        ion = 1;
        step();
        ion = 0;
        ion = 1; iof = 1;
        step();
        ion = 0; iof = 0;
        chk("ion_iof_ien", ien, 0);
        chk("ion_iof_int_req", int_req, 0);

`ifdef IO_IRQ_MASK_EN
        imsk_wr = 1; imsk_data = 2'b01;
        step();
        imsk_wr = 0;
        ion = 1;
        step();
        ion = 0;
        chk("mask_ien", ien, 1);
        chk("mask_int_req", int_req, 0);
        iof = 1;
        step();
        iof = 0;
`endif

        // async reset abandons a pending send
        ac_lo = 8'h5A; out_wr = 1; out_q.push_back(8'h5A);
        step();
        out_wr = 0;
        chk("ar_valid_before", out_valid, 1);
        chk("ar_fgo_before", fgo, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_fgo", fgo, 1);
        chk("ar_out_data", out_data, 0);
        void'(out_q.pop_front());
        step();
        reset = 1'b0;
        step();
        chk("ar_post_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
